// File: rtl/rr_arb_mux.sv
// N-channel valid/ready multiplexer with an internal round-robin or fixed-priority
// arbiter and a one-deep registered output stage.
module rr_arb_mux #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned MODE = 0,
  parameter int unsigned SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*W-1:0]  in_data,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SELW-1:0]   out_sel
);

  logic [W-1:0]    ch_data [NCH];
  logic [W-1:0]    out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] out_sel_q, out_sel_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] cand;
  logic [SELW-1:0] grant_idx;
  logic            grant_found;
  logic            slot_free;
  logic            xfer;

  for (genvar k = 0; k < NCH; k++) begin : g_unpack
    assign ch_data[k] = in_data[k*W +: W];
  end

  // First valid channel at or above the pointer, wrapping modulo NCH.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cand = SELW'((32'(ptr_q) + i) % NCH);
      if (!grant_found && in_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign slot_free = !out_valid_q || out_ready;
  assign xfer      = !rst && slot_free && grant_found;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d  = ch_data[grant_idx];
      out_sel_d   = grant_idx;
      out_valid_d = 1'b1;
      // Fixed-priority mode keeps the pointer at zero so the search always starts at channel 0.
      if (MODE == 0) begin
        ptr_d = (grant_idx == SELW'(NCH - 1)) ? '0 : grant_idx + SELW'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: round-robin NCH=4, fixed-priority NCH=4 and round-robin NCH=3 instances.
module tb_rr_arb_mux;

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [7:0] exp_od;
    logic [1:0] exp_os;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] s;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Round-robin, NCH=4
  logic        rst0, out_valid0, out_ready0;
  logic [31:0] in_data0;
  logic [3:0]  in_valid0, in_ready0;
  logic [7:0]  out_data0;
  logic [1:0]  out_sel0;
  // Fixed priority, NCH=4
  logic        rst1, out_valid1, out_ready1;
  logic [31:0] in_data1;
  logic [3:0]  in_valid1, in_ready1;
  logic [7:0]  out_data1;
  logic [1:0]  out_sel1;
  // Round-robin, NCH=3
  logic        rst2, out_valid2, out_ready2;
  logic [23:0] in_data2;
  logic [2:0]  in_valid2, in_ready2;
  logic [7:0]  out_data2;
  logic [1:0]  out_sel2;

  rr_arb_mux #(.NCH(4), .W(8), .MODE(0)) dut0 (
    .clk(clk), .rst(rst0), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0), .out_sel(out_sel0));

  rr_arb_mux #(.NCH(4), .W(8), .MODE(1)) dut1 (
    .clk(clk), .rst(rst1), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1), .out_sel(out_sel1));

  rr_arb_mux #(.NCH(3), .W(8), .MODE(0)) dut2 (
    .clk(clk), .rst(rst2), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2), .out_sel(out_sel2));

  vec_t tbl [24];
  exp_t sb [$];
  logic [2:0] exp_rdy2 [4];

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic o,
                              input logic [3:0] er, input logic eov, input logic [7:0] eod,
                              input logic [1:0] eos);
    vec_t t;
    t.rst = r; t.vld = v; t.ordy = o; t.exp_rdy = er;
    t.exp_ov = eov; t.exp_od = eod; t.exp_os = eos;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    int   idx;

    //          rst  vld   rdy  exp_rdy ov  od     os
    tbl[0]  = mk(1, 4'hF, 1, 4'h0, 0, 8'h00, 2'd0);
    tbl[1]  = mk(0, 4'hF, 1, 4'h1, 0, 8'h00, 2'd0);
    tbl[2]  = mk(0, 4'hF, 1, 4'h2, 1, 8'h11, 2'd0);
    tbl[3]  = mk(0, 4'hF, 1, 4'h4, 1, 8'h22, 2'd1);
    tbl[4]  = mk(0, 4'hF, 1, 4'h8, 1, 8'h33, 2'd2);
    tbl[5]  = mk(0, 4'hF, 1, 4'h1, 1, 8'h44, 2'd3);
    tbl[6]  = mk(0, 4'hF, 1, 4'h2, 1, 8'h11, 2'd0);
    tbl[7]  = mk(0, 4'hF, 0, 4'h0, 1, 8'h22, 2'd1);
    tbl[8]  = mk(0, 4'hF, 0, 4'h0, 1, 8'h22, 2'd1);
    tbl[9]  = mk(0, 4'hF, 0, 4'h0, 1, 8'h22, 2'd1);
    tbl[10] = mk(0, 4'hF, 1, 4'h4, 1, 8'h22, 2'd1);
    tbl[11] = mk(0, 4'h5, 1, 4'h1, 1, 8'h33, 2'd2);
    tbl[12] = mk(0, 4'h5, 1, 4'h4, 1, 8'h11, 2'd0);
    tbl[13] = mk(0, 4'h5, 1, 4'h1, 1, 8'h33, 2'd2);
    tbl[14] = mk(0, 4'h0, 1, 4'h0, 1, 8'h11, 2'd0);
    tbl[15] = mk(0, 4'h0, 0, 4'h0, 0, 8'h11, 2'd0);
    tbl[16] = mk(0, 4'h8, 0, 4'h8, 0, 8'h11, 2'd0);
    tbl[17] = mk(0, 4'h8, 0, 4'h0, 1, 8'h44, 2'd3);
    tbl[18] = mk(0, 4'h0, 1, 4'h0, 1, 8'h44, 2'd3);
    tbl[19] = mk(0, 4'hF, 1, 4'h1, 0, 8'h44, 2'd3);
    tbl[20] = mk(1, 4'hF, 1, 4'h0, 1, 8'h11, 2'd0);
    tbl[21] = mk(0, 4'h2, 1, 4'h2, 0, 8'h00, 2'd0);
    tbl[22] = mk(0, 4'hF, 1, 4'h4, 1, 8'h22, 2'd1);
    tbl[23] = mk(0, 4'h0, 1, 4'h0, 1, 8'h33, 2'd2);

    exp_rdy2[0] = 3'b001; exp_rdy2[1] = 3'b010; exp_rdy2[2] = 3'b100; exp_rdy2[3] = 3'b001;

    in_data0 = 32'h44332211; in_data1 = 32'h44332211; in_data2 = 24'h332211;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    in_valid0 = 4'hF; in_valid1 = 4'hF; in_valid2 = 3'b111;
    out_ready0 = 1'b1; out_ready1 = 1'b1; out_ready2 = 1'b1;
    tick();

    for (int i = 0; i < 24; i++) begin
      rst0       = tbl[i].rst;
      in_valid0  = tbl[i].vld;
      out_ready0 = tbl[i].ordy;
      #1;
      chk($sformatf("row%0d in_ready", i), 32'(in_ready0), 32'(tbl[i].exp_rdy));
      chk($sformatf("row%0d out_valid", i), 32'(out_valid0), 32'(tbl[i].exp_ov));
      chk($sformatf("row%0d out_data", i), 32'(out_data0), 32'(tbl[i].exp_od));
      chk($sformatf("row%0d out_sel", i), 32'(out_sel0), 32'(tbl[i].exp_os));
      if (i == 0) chk("held-reset in_ready", 32'(in_ready1), 32'h0);
      if (tbl[i].rst) begin
        sb.delete();
      end else begin
        if (out_valid0 && out_ready0) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL row%0d scoreboard: got word %0h/%0d, expected no word", i, out_data0, out_sel0);
          end else begin
            e = sb.pop_front();
            if (out_data0 !== e.d || out_sel0 !== e.s) begin
              errors++;
              $display("FAIL row%0d scoreboard: got %0h/%0d, expected %0h/%0d", i, out_data0, out_sel0, e.d, e.s);
            end
          end
        end
        if (tbl[i].exp_rdy != 4'h0) begin
          idx = 0;
          for (int k = 0; k < 4; k++) if (tbl[i].exp_rdy[k]) idx = k;
          e.d = 8'(8'h11 * (idx + 1));
          e.s = 2'(idx);
          sb.push_back(e);
        end
      end
      tick();
    end
    chk("scoreboard drained", 32'(sb.size()), 32'h0);

    // Fixed priority on dut1, NCH=3 wrap and reset mid-stream on dut2
    rst1 = 1'b0; rst2 = 1'b0;
    in_valid1 = 4'b1110; in_valid2 = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("mode1 c%0d in_ready", i), 32'(in_ready1), 32'h2);
      if (i > 0) begin
        chk($sformatf("mode1 c%0d out_valid", i), 32'(out_valid1), 32'h1);
        chk($sformatf("mode1 c%0d out_sel", i), 32'(out_sel1), 32'h1);
        chk($sformatf("mode1 c%0d out_data", i), 32'(out_data1), 32'h22);
      end
      if (i < 4) chk($sformatf("nch3 c%0d in_ready", i), 32'(in_ready2), 32'(exp_rdy2[i]));
      if (i > 0 && i < 5) begin
        chk($sformatf("nch3 c%0d out_sel", i), 32'(out_sel2), 32'((i - 1) % 3));
        chk($sformatf("nch3 c%0d out_data", i), 32'(out_data2), 32'(8'h11 * (((i - 1) % 3) + 1)));
      end
      if (i == 4) begin
        rst2 = 1'b1;
        #1;
        chk("nch3 reset in_ready", 32'(in_ready2), 32'h0);
      end
      if (i == 5) begin
        chk("nch3 post-reset out_valid", 32'(out_valid2), 32'h0);
        chk("nch3 post-reset out_data", 32'(out_data2), 32'h0);
        rst2 = 1'b0;
        #1;
        chk("nch3 post-reset grant", 32'(in_ready2), 32'h1);
      end
      tick();
    end

    in_valid1 = 4'b1100;
    #1;
    chk("mode1 ch2 in_ready", 32'(in_ready1), 32'h4);
    tick();
    chk("mode1 ch2 out_sel", 32'(out_sel1), 32'h2);
    chk("mode1 ch2 out_data", 32'(out_data1), 32'h33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
